// File: rtl/execute_stage.sv
// MINI-RISC execute stage: D/E register, forwarding ALU, flag logic and E/W register.
// Define MULDIV_EN to implement MUL/DIV; otherwise both produce zero and leave the flags untouched.
module execute_stage #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_D,
  input  logic              flush_D,
  input  logic [4:0]        opcode_D,
  input  logic [2:0]        rd_D,
  input  logic [DATA_W-1:0] reg_data_1_D,
  input  logic [DATA_W-1:0] reg_data_2_D,
  input  logic [7:0]        immediate_D,
  input  logic [3:0]        bit_pos_D,
  input  logic [PC_W-1:0]   pc_D,
  input  logic              alu_src_D,
  input  logic              reg_write_D,
  input  logic              mem_read_D,
  input  logic              mem_write_D,
  input  logic              mem_to_reg_D,
  input  logic [1:0]        write_mode_D,
  input  logic [1:0]        forward_A,
  input  logic [1:0]        forward_B,
  input  logic [DATA_W-1:0] wb_fwd_data,
  input  logic [DATA_W-1:0] current_flags,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [4:0]        opcode_E,
  output logic [2:0]        rd_E,
  output logic              reg_write_E,
  output logic              mem_read_E,
  output logic [PC_W-1:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] next_flags,
  output logic [4:0]        opcode_W,
  output logic [2:0]        rd_W,
  output logic [DATA_W-1:0] wb_data,
  output logic [1:0]        wb_en_0,
  output logic [DATA_W-1:0] wb_data_1,
  output logic [1:0]        wb_en_1
);

  localparam logic [4:0] OP_LBL  = 5'b00001;
  localparam logic [4:0] OP_LBH  = 5'b00010;
  localparam logic [4:0] OP_MOV  = 5'b00011;
  localparam logic [4:0] OP_INC  = 5'b00100;
  localparam logic [4:0] OP_DEC  = 5'b00101;
  localparam logic [4:0] OP_ADD  = 5'b00110;
  localparam logic [4:0] OP_SUB  = 5'b00111;
  localparam logic [4:0] OP_MUL  = 5'b01000;
  localparam logic [4:0] OP_DIV  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_XOR  = 5'b01100;
  localparam logic [4:0] OP_NOT  = 5'b01101;
  localparam logic [4:0] OP_SHL  = 5'b01110;
  localparam logic [4:0] OP_SHR  = 5'b01111;
  localparam logic [4:0] OP_SETB = 5'b10000;
  localparam logic [4:0] OP_CLRB = 5'b10001;
  localparam logic [4:0] OP_CMP  = 5'b10010;
  localparam logic [4:0] OP_LOAD = 5'b10011;
  localparam logic [4:0] OP_STOR = 5'b10100;

  localparam logic [DATA_W:0] ONE_X = 1;

  typedef struct packed {
    logic [4:0]        opcode;
    logic [2:0]        rd;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
    logic [7:0]        imm;
    logic [3:0]        bit_pos;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic [1:0]        write_mode;
  } de_t;

  typedef struct packed {
    logic [4:0]        opcode;
    logic [2:0]        rd;
    logic [DATA_W-1:0] r0;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] mem_data;
    logic              reg_write;
    logic              mem_to_reg;
    logic [1:0]        write_mode;
  } ew_t;

  de_t de_q, de_d;
  ew_t ew_q, ew_d;

  logic [DATA_W-1:0] op_a, op_b, rs2_fwd, bit_mask;
  logic [DATA_W:0]   add_w, sub_w, inc_w, dec_w;
  logic [DATA_W-1:0] r0, r1, flag_src;
  logic              upd, fc, fv;
  logic              unused_pc;

  // The program counter plays no part in execution here.
  assign unused_pc = ^pc_D;

  always_comb begin
    de_d = de_q;
    if (flush_D) begin
      de_d = '0;
    end else if (!stall_D) begin
      de_d.opcode     = opcode_D;
      de_d.rd         = rd_D;
      de_d.rs1        = reg_data_1_D;
      de_d.rs2        = reg_data_2_D;
      de_d.imm        = immediate_D;
      de_d.bit_pos    = bit_pos_D;
      de_d.alu_src    = alu_src_D;
      de_d.reg_write  = reg_write_D;
      de_d.mem_read   = mem_read_D;
      de_d.mem_write  = mem_write_D;
      de_d.mem_to_reg = mem_to_reg_D;
      de_d.write_mode = write_mode_D;
    end
  end

  always_comb begin
    case (forward_A)
      2'b01:   op_a = wb_data;
      2'b10:   op_a = wb_fwd_data;
      default: op_a = de_q.rs1;
    endcase
    case (forward_B)
      2'b01:   rs2_fwd = wb_data;
      2'b10:   rs2_fwd = wb_fwd_data;
      default: rs2_fwd = de_q.rs2;
    endcase
    // The immediate only replaces B when no bypass is selected; stores always take rs2_fwd.
    if ((forward_B == 2'b01) || (forward_B == 2'b10)) op_b = rs2_fwd;
    else if (de_q.alu_src)                            op_b = {8'h00, de_q.imm};
    else                                              op_b = de_q.rs2;
  end

  assign add_w    = {1'b0, op_a} + {1'b0, op_b};
  assign sub_w    = {1'b0, op_a} - {1'b0, op_b};
  assign inc_w    = {1'b0, op_a} + ONE_X;
  assign dec_w    = {1'b0, op_a} - ONE_X;
  assign bit_mask = DATA_W'(1) << de_q.bit_pos;

`ifdef MULDIV_EN
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quot, rem;
  assign prod = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
  assign quot = op_a / op_b;
  assign rem  = op_a % op_b;
`endif

  always_comb begin
    r0  = '0;
    r1  = '0;
    upd = 1'b0;
    fc  = 1'b0;
    fv  = 1'b0;
    case (de_q.opcode)
      OP_LBL:  r0 = {8'h00, de_q.imm};
      OP_LBH:  r0 = {de_q.imm, 8'h00};
      OP_MOV, OP_LOAD, OP_STOR: r0 = op_a;
      OP_INC:  begin r0 = inc_w[DATA_W-1:0]; fc = inc_w[DATA_W]; fv = ~op_a[15] & r0[15]; upd = 1'b1; end
      OP_DEC:  begin r0 = dec_w[DATA_W-1:0]; fc = dec_w[DATA_W]; fv = op_a[15] & ~r0[15]; upd = 1'b1; end
      OP_ADD:  begin
        r0 = add_w[DATA_W-1:0]; fc = add_w[DATA_W];
        fv = (op_a[15] == op_b[15]) && (r0[15] != op_a[15]); upd = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        r0 = (de_q.opcode == OP_SUB) ? sub_w[DATA_W-1:0] : '0;
        fc = sub_w[DATA_W];
        fv = (op_a[15] != op_b[15]) && (sub_w[15] != op_a[15]); upd = 1'b1;
      end
      OP_MUL: begin
`ifdef MULDIV_EN
        r0 = prod[DATA_W-1:0]; r1 = prod[2*DATA_W-1:DATA_W]; upd = 1'b1;
`endif
      end
      OP_DIV: begin
`ifdef MULDIV_EN
        if (op_b == '0) begin r0 = '1; r1 = op_a; fv = 1'b1; end
        else            begin r0 = quot; r1 = rem; end
        upd = 1'b1;
`endif
      end
      OP_AND:  begin r0 = op_a & op_b; upd = 1'b1; end
      OP_OR:   begin r0 = op_a | op_b; upd = 1'b1; end
      OP_XOR:  begin r0 = op_a ^ op_b; upd = 1'b1; end
      OP_NOT:  begin r0 = ~op_a;       upd = 1'b1; end
      OP_SHL:  begin r0 = {op_a[14:0], 1'b0}; fc = op_a[15]; upd = 1'b1; end
      OP_SHR:  begin r0 = {1'b0, op_a[15:1]}; fc = op_a[0];  upd = 1'b1; end
      OP_SETB: r0 = op_a | bit_mask;
      OP_CLRB: r0 = op_a & ~bit_mask;
      default: r0 = '0;
    endcase
  end

  // CMP discards its difference but still derives Z and N from it.
  assign flag_src   = (de_q.opcode == OP_CMP) ? sub_w[DATA_W-1:0] : r0;
  assign next_flags = upd ? {{(DATA_W-4){1'b0}}, fv, flag_src[15], fc, ~|flag_src} : current_flags;

  always_comb begin
    ew_d            = '0;
    ew_d.opcode     = de_q.opcode;
    ew_d.rd         = de_q.rd;
    ew_d.r0         = r0;
    ew_d.r1         = r1;
    ew_d.mem_data   = mem_read_data;
    ew_d.reg_write  = de_q.reg_write;
    ew_d.mem_to_reg = de_q.mem_to_reg;
    ew_d.write_mode = de_q.write_mode;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_q <= '0;
      ew_q <= '0;
    end else begin
      de_q <= de_d;
      ew_q <= ew_d;
    end
  end

  assign opcode_E    = de_q.opcode;
  assign rd_E        = de_q.rd;
  assign reg_write_E = de_q.reg_write;
  assign mem_read_E  = de_q.mem_read;
  assign mem_addr    = r0[PC_W-1:0];
  assign mem_wdata   = rs2_fwd;
  assign mem_we      = de_q.mem_write;

  assign opcode_W  = ew_q.opcode;
  assign rd_W      = ew_q.rd;
  assign wb_data   = ew_q.mem_to_reg ? ew_q.mem_data : ew_q.r0;
  assign wb_en_0   = ew_q.reg_write ? ew_q.write_mode : 2'b00;
  assign wb_data_1 = ew_q.r1;
`ifdef MULDIV_EN
  assign wb_en_1   = ((ew_q.opcode == OP_MUL) || (ew_q.opcode == OP_DIV)) ? 2'b11 : 2'b00;
`else
  assign wb_en_1   = 2'b00;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vectors, an arithmetic reference model of both
// pipeline registers checked every cycle, and hand-computed literal expectations.
module tb_execute_stage;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [2:0]  rd;
    logic [15:0] rs1;
    logic [15:0] rs2;
    logic [7:0]  imm;
    logic [3:0]  bp;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [1:0]  wm;
  } de_t;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [2:0]  rd;
    logic [15:0] r0;
    logic [15:0] r1;
    logic [15:0] mdata;
    logic        reg_write;
    logic        mem_to_reg;
    logic [1:0]  wm;
  } ew_t;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        as;
    logic [7:0]  imm;
    logic [3:0]  bp;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] fwd;
    logic [10:0] addr;
    logic [15:0] flags;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall_D = 1'b0, flush_D = 1'b0;
  de_t         d_in = '0;
  logic [10:0] pc_D = '0;
  logic [1:0]  forward_A = 2'b00, forward_B = 2'b00;
  logic [15:0] wb_fwd_data = '0, current_flags = '0, mem_read_data = '0;

  logic [4:0]  opcode_E, opcode_W;
  logic [2:0]  rd_E, rd_W;
  logic        reg_write_E, mem_read_E, mem_we;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata, next_flags, wb_data, wb_data_1;
  logic [1:0]  wb_en_0, wb_en_1;

  de_t  m_de = '0;
  ew_t  m_ew = '0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  vec_t vecs[18];

  execute_stage dut (
    .clk(clk), .reset_n(reset_n), .stall_D(stall_D), .flush_D(flush_D),
    .opcode_D(d_in.opcode), .rd_D(d_in.rd), .reg_data_1_D(d_in.rs1), .reg_data_2_D(d_in.rs2),
    .immediate_D(d_in.imm), .bit_pos_D(d_in.bp), .pc_D(pc_D),
    .alu_src_D(d_in.alu_src), .reg_write_D(d_in.reg_write), .mem_read_D(d_in.mem_read),
    .mem_write_D(d_in.mem_write), .mem_to_reg_D(d_in.mem_to_reg), .write_mode_D(d_in.wm),
    .forward_A(forward_A), .forward_B(forward_B), .wb_fwd_data(wb_fwd_data),
    .current_flags(current_flags), .mem_read_data(mem_read_data),
    .opcode_E(opcode_E), .rd_E(rd_E), .reg_write_E(reg_write_E), .mem_read_E(mem_read_E),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .next_flags(next_flags),
    .opcode_W(opcode_W), .rd_W(rd_W), .wb_data(wb_data), .wb_en_0(wb_en_0),
    .wb_data_1(wb_data_1), .wb_en_1(wb_en_1)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic int sgn(input logic [15:0] x);
    return x[15] ? int'(x) - 65536 : int'(x);
  endfunction

  function automatic logic [15:0] m_wb();
    return m_ew.mem_to_reg ? m_ew.mdata : m_ew.r0;
  endfunction

  // Reference model of the E stage, written from the instruction-set rules.
  function automatic void e_model(output logic [15:0] r0, output logic [15:0] r1,
                                  output logic [15:0] nf, output logic [15:0] wd);
    logic [15:0] a, b, fr;
    int ia, ib, s;
    longint p;
    bit upd, c, v;
    a  = (forward_A == 2'd1) ? m_wb() : (forward_A == 2'd2) ? wb_fwd_data : m_de.rs1;
    wd = (forward_B == 2'd1) ? m_wb() : (forward_B == 2'd2) ? wb_fwd_data : m_de.rs2;
    b  = ((forward_B == 2'd0 || forward_B == 2'd3) && m_de.alu_src) ? {8'h00, m_de.imm} : wd;
    ia = int'(a); ib = int'(b); s = 0; p = 0;
    r0 = '0; r1 = '0; upd = 1'b1; c = 1'b0; v = 1'b0;
    case (m_de.opcode)
      5'd1:  begin r0 = {8'h00, m_de.imm}; upd = 1'b0; end
      5'd2:  begin r0 = {m_de.imm, 8'h00}; upd = 1'b0; end
      5'd3, 5'd19, 5'd20: begin r0 = a; upd = 1'b0; end
      5'd4:  begin s = ia + 1; c = (s > 65535); v = (sgn(a) + 1 > 32767); r0 = s[15:0]; end
      5'd5:  begin s = ia - 1; c = (ia < 1); v = (sgn(a) - 1 < -32768); r0 = s[15:0]; end
      5'd6:  begin
        s = ia + ib; c = (s > 65535);
        v = (sgn(a) + sgn(b) > 32767) || (sgn(a) + sgn(b) < -32768); r0 = s[15:0];
      end
      5'd7, 5'd18: begin
        s = ia - ib; c = (ia < ib);
        v = (sgn(a) - sgn(b) > 32767) || (sgn(a) - sgn(b) < -32768);
        r0 = (m_de.opcode == 5'd7) ? s[15:0] : 16'h0000;
      end
`ifdef MULDIV_EN
      5'd8:  begin p = longint'(ia) * longint'(ib); r0 = p[15:0]; r1 = p[31:16]; end
      5'd9:  begin
        if (ib == 0) begin r0 = 16'hFFFF; r1 = a; v = 1'b1; end
        else begin r0 = 16'(ia / ib); r1 = 16'(ia % ib); end
      end
`endif
      5'd10: r0 = a & b;
      5'd11: r0 = a | b;
      5'd12: r0 = a ^ b;
      5'd13: r0 = ~a;
      5'd14: begin s = ia * 2; c = a[15]; r0 = s[15:0]; end
      5'd15: begin r0 = 16'(ia / 2); c = a[0]; end
      5'd16: begin r0 = a | 16'(1 << m_de.bp); upd = 1'b0; end
      5'd17: begin r0 = a & ~16'(1 << m_de.bp); upd = 1'b0; end
      default: begin r0 = '0; upd = 1'b0; end
    endcase
    fr = (m_de.opcode == 5'd18) ? s[15:0] : r0;
    nf = upd ? {12'h000, v, fr[15], c, (fr == 16'h0000)} : current_flags;
  endfunction

  // Driver: advance one clock, moving the model pipeline alongside the DUT.
  task automatic tick();
    de_t nd;
    ew_t nw;
    logic [15:0] r0, r1, nf, wd;
    e_model(r0, r1, nf, wd);
    nw.opcode = m_de.opcode; nw.rd = m_de.rd; nw.r0 = r0; nw.r1 = r1;
    nw.mdata = mem_read_data; nw.reg_write = m_de.reg_write;
    nw.mem_to_reg = m_de.mem_to_reg; nw.wm = m_de.wm;
    if (flush_D)      nd = '0;
    else if (stall_D) nd = m_de;
    else              nd = d_in;
    if (!reset_n) begin nd = '0; nw = '0; end
    @(posedge clk);
    m_de = nd;
    m_ew = nw;
    #1;
    pc_D = pc_D + 11'd1;
  endtask

  task automatic set_d(input logic [4:0] op, input logic [2:0] rd, input logic [15:0] a,
                       input logic [15:0] b, input logic [7:0] imm, input logic as,
                       input logic rw, input logic mr, input logic mw, input logic m2r,
                       input logic [1:0] wm);
    d_in = '0;
    d_in.opcode = op; d_in.rd = rd; d_in.rs1 = a; d_in.rs2 = b; d_in.imm = imm;
    d_in.alu_src = as; d_in.reg_write = rw; d_in.mem_read = mr; d_in.mem_write = mw;
    d_in.mem_to_reg = m2r; d_in.wm = wm;
  endtask

  // Scoreboard: every negedge the DUT must agree with the model.
  always @(negedge clk) begin
    logic [15:0] r0, r1, nf, wd;
    logic [1:0] en1;
    if (chk_en) begin
      e_model(r0, r1, nf, wd);
`ifdef MULDIV_EN
      en1 = (m_ew.opcode == 5'd8 || m_ew.opcode == 5'd9) ? 2'b11 : 2'b00;
`else
      en1 = 2'b00;
`endif
      chk("opcode_E", 32'(opcode_E), 32'(m_de.opcode));
      chk("rd_E", 32'(rd_E), 32'(m_de.rd));
      chk("reg_write_E", 32'(reg_write_E), 32'(m_de.reg_write));
      chk("mem_read_E", 32'(mem_read_E), 32'(m_de.mem_read));
      chk("mem_addr", 32'(mem_addr), 32'(r0[10:0]));
      chk("mem_wdata", 32'(mem_wdata), 32'(wd));
      chk("mem_we", 32'(mem_we), 32'(m_de.mem_write));
      chk("next_flags", 32'(next_flags), 32'(nf));
      chk("opcode_W", 32'(opcode_W), 32'(m_ew.opcode));
      chk("rd_W", 32'(rd_W), 32'(m_ew.rd));
      chk("wb_data", 32'(wb_data), 32'(m_wb()));
      chk("wb_en_0", 32'(wb_en_0), 32'(m_ew.reg_write ? m_ew.wm : 2'b00));
      chk("wb_data_1", 32'(wb_data_1), 32'(m_ew.r1));
      chk("wb_en_1", 32'(wb_en_1), 32'(en1));
    end
  end

  initial begin
    //          op     a         b         as    imm    bp    fa    fb    fwd       addr     flags
    vecs[0]  = '{5'd6,  16'h7FFF, 16'h0001, 1'b0, 8'h00, 4'd0, 2'd0, 2'd0, 16'h0000, 11'h000, 16'h000C};
    vecs[1]  = '{5'd7,  16'h0000, 16'h0001, 1'b0, 8'h00, 4'd0, 2'd0, 2'd0, 16'h0000, 11'h7FF, 16'h0006};
    vecs[2]  = '{5'd18, 16'h0005, 16'h0005, 1'b0, 8'h00, 4'd0, 2'd0, 2'd0, 16'h0000, 11'h000, 16'h0001};
    vecs[3]  = '{5'd10, 16'hF0F0, 16'hFF00, 1'b0, 8'h00, 4'd0, 2'd0, 2'd0, 16'h0000, 11'h000, 16'h0004};
    vecs[4]  = '{5'd11, 16'h0F00, 16'h00F0, 1'b0, 8'h00, 4'd0, 2'd0, 2'd0, 16'h0000, 11'h7F0, 16'h0000};
    vecs[5]  = '{5'd12, 16'hAAAA, 16'hAAAA, 1'b0, 8'h00, 4'd0, 2'd0, 2'd0, 16'h0000, 11'h000, 16'h0001};
    vecs[6]  = '{5'd13, 16'h00FF, 16'h0000, 1'b0, 8'h00, 4'd0, 2'd0, 2'd0, 16'h0000, 11'h700, 16'h0004};
    vecs[7]  = '{5'd14, 16'h8001, 16'h0000, 1'b0, 8'h00, 4'd0, 2'd0, 2'd0, 16'h0000, 11'h002, 16'h0002};
    vecs[8]  = '{5'd15, 16'h0003, 16'h0000, 1'b0, 8'h00, 4'd0, 2'd0, 2'd0, 16'h0000, 11'h001, 16'h0002};
    vecs[9]  = '{5'd16, 16'h0000, 16'h0000, 1'b0, 8'h00, 4'd15, 2'd0, 2'd0, 16'h0000, 11'h000, 16'h000A};
    vecs[10] = '{5'd17, 16'hFFFF, 16'h0000, 1'b0, 8'h00, 4'd0, 2'd0, 2'd0, 16'h0000, 11'h7FE, 16'h000A};
    vecs[11] = '{5'd5,  16'h8000, 16'h0000, 1'b0, 8'h00, 4'd0, 2'd0, 2'd0, 16'h0000, 11'h7FF, 16'h0008};
    vecs[12] = '{5'd21, 16'h1234, 16'h0000, 1'b0, 8'h00, 4'd0, 2'd0, 2'd0, 16'h0000, 11'h000, 16'h000A};
    vecs[13] = '{5'd31, 16'h1234, 16'h5678, 1'b0, 8'h00, 4'd0, 2'd0, 2'd0, 16'h0000, 11'h000, 16'h000A};
    vecs[14] = '{5'd6,  16'h0020, 16'h9999, 1'b1, 8'h10, 4'd0, 2'd0, 2'd0, 16'h0000, 11'h030, 16'h0000};
    vecs[15] = '{5'd7,  16'h0001, 16'h7777, 1'b0, 8'h00, 4'd0, 2'd0, 2'd2, 16'h0001, 11'h000, 16'h0001};
    vecs[16] = '{5'd3,  16'hFFFF, 16'h0000, 1'b0, 8'h00, 4'd0, 2'd2, 2'd0, 16'h0001, 11'h001, 16'h000A};
    vecs[17] = '{5'd6,  16'hFFFF, 16'h0001, 1'b0, 8'h00, 4'd0, 2'd0, 2'd0, 16'h0000, 11'h000, 16'h0003};

    // Reset
    #1 reset_n = 1'b0;
    #1;
    chk("rst_opcode_W", 32'(opcode_W), 32'h0);
    chk("rst_wb_en_0", 32'(wb_en_0), 32'h0);
    chk("rst_wb_data", 32'(wb_data), 32'h0);
    chk_en = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("nop_wb_data", 32'(wb_data), 32'h0);
    chk("nop_opcode_W", 32'(opcode_W), 32'h0);

    // Load byte
    set_d(5'd1, 3'd0, 16'h0000, 16'h0000, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
    tick();
    set_d(5'd2, 3'd2, 16'h0000, 16'h0000, 8'hAB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
    tick();
    chk("lbl_wb_data", 32'(wb_data), 32'h0001);
    chk("lbl_wb_en_0", 32'(wb_en_0), 32'h1);
    chk("lbl_rd_W", 32'(rd_W), 32'h0);
    set_d(5'd0, 3'd0, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    chk("lbh_wb_data", 32'(wb_data), 32'hAB00);
    chk("lbh_wb_en_0", 32'(wb_en_0), 32'h2);

    // Forwarding from the W stage
    set_d(5'd1, 3'd1, 16'h0000, 16'h0000, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
    tick();
    set_d(5'd4, 3'd1, 16'h5555, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
    tick();
    forward_A = 2'b01;
    #1;
    chk("inc_fwd_addr", 32'(mem_addr), 32'h002);
    chk("inc_fwd_flags", 32'(next_flags), 32'h0000);
    set_d(5'd4, 3'd2, 16'hFFFF, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
    tick();
    forward_A = 2'b00;
    chk("inc_fwd_wb", 32'(wb_data), 32'h0002);
    #1;
    chk("inc_wrap_addr", 32'(mem_addr), 32'h000);
    chk("inc_wrap_flags", 32'(next_flags), 32'h0003);

    // MUL / DIV
    set_d(5'd8, 3'd3, 16'h1234, 16'h0100, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
    tick();
    set_d(5'd9, 3'd4, 16'h0007, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
    tick();
`ifdef MULDIV_EN
    chk("mul_r0", 32'(wb_data), 32'h3400);
    chk("mul_r1", 32'(wb_data_1), 32'h0012);
    chk("mul_en1", 32'(wb_en_1), 32'h3);
    chk("div0_flags", 32'(next_flags), 32'h000C);
`else
    chk("mul_r0", 32'(wb_data), 32'h0000);
    chk("mul_en1", 32'(wb_en_1), 32'h0);
    chk("div0_flags", 32'(next_flags), 32'h0000);
`endif
    set_d(5'd0, 3'd0, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
`ifdef MULDIV_EN
    chk("div0_r0", 32'(wb_data), 32'hFFFF);
    chk("div0_r1", 32'(wb_data_1), 32'h0007);
`else
    chk("div0_r0", 32'(wb_data), 32'h0000);
    chk("div0_r1", 32'(wb_data_1), 32'h0000);
`endif

    // Stall / flush
    set_d(5'd6, 3'd5, 16'h0003, 16'h0004, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
    tick();
    set_d(5'd7, 3'd6, 16'h0009, 16'h0001, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
    stall_D = 1'b1;
    tick();
    chk("stall1_opcode_E", 32'(opcode_E), 32'd6);
    tick();
    chk("stall2_opcode_E", 32'(opcode_E), 32'd6);
    chk("stall_wb_data", 32'(wb_data), 32'h0007);
    flush_D = 1'b1;
    tick();
    chk("flush_opcode_E", 32'(opcode_E), 32'd0);
    chk("flush_reg_write_E", 32'(reg_write_E), 32'd0);
    flush_D = 1'b0;
    stall_D = 1'b0;

    // Memory interface
    set_d(5'd20, 3'd0, 16'h0123, 16'hBEEF, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    chk("st_addr", 32'(mem_addr), 32'h123);
    chk("st_wdata", 32'(mem_wdata), 32'hBEEF);
    chk("st_we", 32'(mem_we), 32'h1);
    set_d(5'd19, 3'd6, 16'h0040, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
    tick();
    chk("ld_mem_read_E", 32'(mem_read_E), 32'h1);
    mem_read_data = 16'h5A5A;
    set_d(5'd0, 3'd0, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    mem_read_data = 16'h0000;
    #1;
    chk("ld_wb_data", 32'(wb_data), 32'h5A5A);
    chk("ld_wb_en_0", 32'(wb_en_0), 32'h3);

    // Operation table with hand-computed address and flags
    current_flags = 16'h000A;
    for (int i = 0; i < 18; i++) begin
      set_d(vecs[i].op, 3'(i), vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].as,
            1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
      d_in.bp = vecs[i].bp;
      tick();
      forward_A = vecs[i].fa;
      forward_B = vecs[i].fb;
      wb_fwd_data = vecs[i].fwd;
      #1;
      chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_flags", i), 32'(next_flags), 32'(vecs[i].flags));
    end
    set_d(5'd0, 3'd0, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    forward_A = 2'b00; forward_B = 2'b00; wb_fwd_data = 16'h0000; current_flags = 16'h0000;
    tick();

    // Asynchronous reset while instructions are in flight
    set_d(5'd6, 3'd7, 16'h0003, 16'h0004, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
    tick();
    set_d(5'd11, 3'd1, 16'h00F0, 16'h000F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
    tick();
    chk("pre_rst_wb_data", 32'(wb_data), 32'h0007);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_opcode_W", 32'(opcode_W), 32'h0);
    chk("mid_rst_wb_en_0", 32'(wb_en_0), 32'h0);
    chk("mid_rst_wb_data", 32'(wb_data), 32'h0);
    chk("mid_rst_opcode_E", 32'(opcode_E), 32'h0);
    m_de = '0;
    m_ew = '0;
    tick();
    reset_n = 1'b1;
    set_d(5'd0, 3'd0, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick(); tick();

    // Final report
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
